// File: rtl/seq_alu_pkg.sv
// seq_alu shared types: function encoding and control states.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        ADD  = 3'b000,
        MUL  = 3'b001,
        LSL  = 3'b010,
        LSR  = 3'b011,
        ORR  = 3'b100,
        ANDR = 3'b101,
        CAT  = 3'b110,
        HOLD = 3'b111
    } alu_fn_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL_RUN = 1'b1
    } state_e;

endpackage

// File: rtl/shift_add_mult.sv
// Iterative unsigned shift-add multiplier, one bit of a per step.
module shift_add_mult #(
    parameter int N = 4
) (
    input  logic           Clock,
    input  logic           Reset_b,
    input  logic           load,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           step,
    output logic [2*N-1:0] product
);

    logic [2*N-1:0] acc;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;

    // Partial product including the pending step, so the last step can commit directly
    assign product = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{N{1'b0}}, b};
            mplier <= a;
        end else if (step) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered accumulator ALU: operand B is the low half of ALUout.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           Clock,
    input  logic           Reset_b,
    input  logic [N-1:0]   Data,
    input  logic [2:0]     Function,
    input  logic           Start,
    output logic           Busy,
    output logic           Done,
    output logic [2*N-1:0] ALUout
);

    localparam int CW = $clog2(N + 1);

    state_e         state;
    logic [CW-1:0]  cnt;
    alu_fn_e        fn;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] wide_b;
    logic [2*N-1:0] res;
    logic [2*N-1:0] product;
    logic           accept;
    logic           mul_load;

    assign fn       = alu_fn_e'(Function);
    assign a        = Data;
    assign b        = ALUout[N-1:0];
    assign wide_b   = {{N{1'b0}}, b};
    assign accept   = (state == IDLE) && Start;
    assign mul_load = accept && (fn == MUL);

    always_comb begin
        res = ALUout;
        unique case (fn)
            ADD:  res = {{(N-1){1'b0}}, {1'b0, a} + {1'b0, b}};
            LSL:  res = (32'(a) >= 2 * N) ? '0 : wide_b << a;
            LSR:  res = (32'(a) >= 2 * N) ? '0 : wide_b >> a;
            ORR:  res = {{(2*N-1){1'b0}}, |{a, b}};
            ANDR: res = {{(2*N-1){1'b0}}, &{a, b}};
            CAT:  res = {a, b};
            MUL,
            HOLD: res = ALUout;
        endcase
    end

    shift_add_mult #(.N(N)) u_mult (
        .Clock   (Clock),
        .Reset_b (Reset_b),
        .load    (mul_load),
        .a       (a),
        .b       (b),
        .step    (state == MUL_RUN),
        .product (product)
    );

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            state  <= IDLE;
            cnt    <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            ALUout <= '0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mul_load) begin
                        state <= MUL_RUN;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                    end else if (accept) begin
                        ALUout <= res;
                        Done   <= 1'b1;
                    end
                end
                MUL_RUN: begin
                    if (cnt == CW'(N - 1)) begin
                        state  <= IDLE;
                        Busy   <= 1'b0;
                        Done   <= 1'b1;
                        ALUout <= product;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Registered, parametrised successor to the lab combinational ALU.
- Operand A comes from the Data input. Operand B is fed back from the low N bits of the registered result, so the block behaves as an accumulator.
- Adds shifts and an iterative shift-add multiplier.
- Uses a Start/Busy/Done handshake. Sits between the switch/key inputs and the HEX display path.

Parameters:
- N, 4, operand width. Result width is 2N. N >= 2.

Ports:
- Clock  input  1  rising-edge clock.
- Reset_b  input  1  asynchronous, active-low reset.
- Data  input  N  operand A.
- Function  input  3  operation select, sampled with Start.
- Start  input  1  request. Sampled on the rising edge when Busy=0.
- Busy  output  1  multiply in progress.
- Done  output  1  one-cycle pulse when a result is committed.
- ALUout  output  2N  registered result. ALUout[N-1:0] is operand B.

Behaviour:
- Reset (Reset_b=0, asynchronous): ALUout=0, Busy=0, Done=0, FSM in IDLE, multiplier datapath cleared.
- Reset asserted mid-multiply aborts the operation. No Done pulse is produced.
- Operand capture: on an edge with Start=1 and Busy=0, latch A=Data, B=ALUout[N-1:0] and Function. Later changes to Data or Function do not affect the in-flight operation.
- Start while Busy=1 is ignored: no queueing, no error.
- Function encoding:
  - 000 ADD: A+B. The (N+1)-bit sum is zero-extended to 2N.
  - 001 MUL: A*B. Full 2N-bit product, unsigned.
  - 010 LSL: ({N'b0,B} << A). Result is 0 if A >= 2N.
  - 011 LSR: ({N'b0,B} >> A). Result is 0 if A >= 2N.
  - 100 ORR: reduction OR of {A,B}, in bit 0; other bits 0.
  - 101 ANDR: reduction AND of {A,B}, in bit 0; other bits 0.
  - 110 CAT: {A,B}.
  - 111 HOLD: ALUout unchanged, Done still pulses.
- Single-cycle operations (all except MUL): on the Start edge k, ALUout loads the result and Done=1 for cycle k+1 only. Busy stays 0.
- MUL timing:
  - On edge k, Busy goes to 1 and the multiplier is loaded.
  - Edges k+1..k+N each perform one shift-add iteration over bit i of A.
  - On edge k+N, the product is loaded into ALUout, Busy goes to 0 and Done=1 for one cycle.
  - Latency from Start edge to result is N cycles. Busy is high for exactly N cycles.
  - A new Start is accepted on edge k+N+1 or later.
- ALUout does not change during a multiply until commit.
- Done is never high in two consecutive cycles unless back-to-back single-cycle Starts are issued. Back-to-back single-cycle Starts are legal: one result per cycle, Done held high.
- FSM states:
  - IDLE: on Start, go to MUL if Function=MUL, else stay in IDLE and commit the result.
  - MUL: counter counts 0..N-1; at N-1 commit the product and return to IDLE.
  - Iteration counter width is $clog2(N+1).
- All arithmetic is unsigned. There is no overflow or carry flag; the 2N-bit width holds every result exactly.

Decomposition:
- Shared package seq_alu_pkg holds:
  - typedef enum logic [2:0] alu_fn_e with values ADD, MUL, LSL, LSR, ORR, ANDR, CAT, HOLD, encoded 000..111 as above;
  - typedef enum state_e with values IDLE and MUL.
- Sub-module shift_add_mult (parameter N). Ports: Clock, Reset_b, load, a, b, step, product. It holds the partial product and multiplicand/multiplier shift registers.
- The top level holds the FSM, counter, operand latches, combinational result mux and ALUout register.

Test Plan (N=4):
- Reset → Reset_b=0 for 2 cycles with Start=1 → ALUout=8'h00, Busy=0, Done=0 throughout. Release → no Done until the first Start.
- Accumulate → ADD Data=5 → ALUout=8'h05 and Done pulse next cycle. Then ADD Data=F → ALUout=8'h14 (5+15).
- Multiply → with ALUout=8'h14 (B=4), MUL Data=F:
  - Busy high exactly 4 cycles;
  - ALUout stays 8'h14 until commit;
  - then ALUout=8'h3C with one Done pulse.
  - Also MUL F*F from B=F gives 8'hE1.
- Shift → B=3: LSL Data=2 gives 8'h0C; LSR Data=1 from B=C gives 8'h06; LSL Data=9 gives 8'h00.
- Reduce/concat → B=F, Data=F: ANDR gives 8'h01. B=0, Data=0: ORR gives 8'h00. B=5, Data=A: CAT gives 8'hA5. HOLD leaves ALUout unchanged with a Done pulse.
- Protocol → Start held high during MUL is ignored (a single Done, product correct). Reset_b pulsed low at iteration 2 of a MUL gives ALUout=0, Busy=0, no Done. Back-to-back ADD Starts on consecutive cycles give a Done=1 stream.
